muldiv_ctrl: RTL and testbench

//  Sequencer for the EX-stage multiply/divide resources; owns the HI/LO registers.

---
 rtl/muldiv_ctrl_pkg.sv | 27 ++
 rtl/muldiv_ctrl_div_iter.sv | 60 ++++++
 rtl/muldiv_ctrl.sv | 135 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared op codes, FSM state encoding and sign helper for the EX-stage mul/div sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_OP_MULT  = 3'd0,
    MD_OP_MULTU = 3'd1,
    MD_OP_DIV   = 3'd2,
    MD_OP_DIVU  = 3'd3,
    MD_OP_MTHI  = 3'd4,
    MD_OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  localparam int DATA_W = 32;

  // Two's-complement negate when neg is set; 0x80000000 maps to itself.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring radix-2 unsigned divider: one quotient bit per cycle, done pulses with the last bit.
module div_iter #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        done
);

  localparam int CW = $clog2(DIV_CYCLES);

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rem_q, quot_q, dvsr_q;
  logic [32:0]   partial, diff;
  logic          take;
  logic [31:0]   rem_d, quot_d;

  // quot_q doubles as the dividend shift register; quotient bits fill in from the LSB.
  always_comb begin
    partial = {rem_q, quot_q[31]};
    diff    = partial - {1'b0, dvsr_q};
    take    = ~diff[32];
    rem_d   = take ? diff[31:0] : partial[31:0];
    quot_d  = {quot_q[30:0], take};
  end

  // Result is presented combinationally on the final iteration so the caller commits that edge.
  assign done = run_q & (cnt_q == CW'(DIV_CYCLES - 1));
  assign quot = quot_d;
  assign rem  = rem_d;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
    end else if (start) begin
      run_q  <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= dividend;
      dvsr_q <= divisor;
    end else if (run_q) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, drives the external mul unit, runs the divider.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT    = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  output logic        mul_signed_o,
  output logic [31:0] mul_ina_o,
  output logic [31:0] mul_inb_o,
  input  logic [63:0] mul_result_i,
  output logic        stallreq_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CNT_W = $clog2(MUL_LAT) + 1;

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q;
  logic             neg_quot_q, neg_rem_q;

  logic        is_mul, is_div, accept, mul_act;
  logic        a_neg, b_neg, div_start, div_done;
  logic [31:0] div_quot, div_rem;

  assign is_mul = (op_i == MD_OP_MULT) || (op_i == MD_OP_MULTU);
  assign is_div = (op_i == MD_OP_DIV)  || (op_i == MD_OP_DIVU);
  assign accept = ~rst & ~flush_i & op_valid_i & (state_q == MD_IDLE);

  assign a_neg     = (op_i == MD_OP_DIV) & src_a_i[31];
  assign b_neg     = (op_i == MD_OP_DIV) & src_b_i[31];
  assign div_start = accept & is_div & (src_b_i != 32'd0);

  // Operands stay stable through MUL, so the mul unit sees them for the whole latency window.
  assign mul_act      = ~rst & ((state_q == MD_MUL) | (accept & is_mul));
  assign mul_signed_o = mul_act & (op_i == MD_OP_MULT);
  assign mul_ina_o    = mul_act ? src_a_i : 32'd0;
  assign mul_inb_o    = mul_act ? src_b_i : 32'd0;

  always_comb begin
    stallreq_o = 1'b0;
    if (!rst && !flush_i) begin
      unique case (state_q)
        MD_IDLE: stallreq_o = op_valid_i & (is_mul | is_div);
        MD_MUL:  stallreq_o = 1'b1;
        MD_DIV:  stallreq_o = 1'b1;
        MD_DONE: stallreq_o = 1'b0;
        default: stallreq_o = 1'b0;
      endcase
    end
  end

  assign busy_o = (state_q != MD_IDLE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .rst      (rst),
    .abort    (flush_i),
    .start    (div_start),
    .dividend (cond_neg(src_a_i, a_neg)),
    .divisor  (cond_neg(src_b_i, b_neg)),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (flush_i) begin
      // Abort wins over any commit scheduled for this edge.
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (op_valid_i) begin
            if (is_mul) begin
              cnt_q   <= '0;
              state_q <= MD_MUL;
            end else if (is_div) begin
              if (src_b_i == 32'd0) begin
                lo_q    <= 32'hFFFF_FFFF;
                hi_q    <= src_a_i;
                state_q <= MD_DONE;
              end else begin
                neg_quot_q <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                state_q    <= MD_DIV;
              end
            end else if (op_i == MD_OP_MTHI) begin
              hi_q <= src_a_i;
            end else if (op_i == MD_OP_MTLO) begin
              lo_q <= src_a_i;
            end
          end
        end
        MD_MUL: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
            {hi_q, lo_q} <= mul_result_i;
            state_q      <= MD_DONE;
          end
        end
        MD_DIV: begin
          if (div_done) begin
            hi_q    <= cond_neg(div_rem, neg_rem_q);
            lo_q    <= cond_neg(div_quot, neg_quot_q);
            state_q <= MD_DONE;
          end
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural 2-cycle mul unit.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, op_valid;
  logic [2:0]  op_r;
  logic [31:0] src_a, src_b;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result, p1, prod, ea, eb;
  logic        stallreq, busy;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(2), .DIV_CYCLES(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .op_valid_i   (op_valid),
    .op_i         (op_r),
    .src_a_i      (src_a),
    .src_b_i      (src_b),
    .mul_signed_o (mul_signed),
    .mul_ina_o    (mul_ina),
    .mul_inb_o    (mul_inb),
    .mul_result_i (mul_result),
    .stallreq_o   (stallreq),
    .busy_o       (busy),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  // Mul unit: two register stages, result valid two cycles after operands.
  always_comb begin
    ea   = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'd0, mul_ina};
    eb   = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'd0, mul_inb};
    prod = ea * eb;
  end

  always_ff @(posedge clk) begin
    p1         <= prod;
    mul_result <= p1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; holds the op until the first non-stall cycle, returns at posedge+1.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output logic [31:0] ina0, output logic dbusy,
                       output logic [31:0] dhi, output logic [31:0] dlo);
    op_valid = 1'b1; op_r = op; src_a = a; src_b = b;
    stalls = 0; ina0 = '0; dbusy = 1'b0; dhi = '0; dlo = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) ina0 = mul_ina;
      if (!stallreq) begin
        dbusy = busy; dhi = hi; dlo = lo;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  int          st;
  logic [31:0] ina0, dhi, dlo;
  logic        dbusy;

  initial begin
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op_r = MD_OP_MULT; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_stall", stallreq, 0);
    chk("reset_busy", busy, 0);
    chk("reset_mul_ina", mul_ina, 0);
    @(posedge clk); #1;

    do_op(MD_OP_MULT, 32'hFFFF_FFFD, 32'd7, st, ina0, dbusy, dhi, dlo);
    chk("mult_stalls", st, 3);
    chk("mult_ina", ina0, 64'hFFFF_FFFD);
    chk("mult_done_busy", dbusy, 1);
    chk("mult_hi", hi, 64'hFFFF_FFFF);
    chk("mult_lo", lo, 64'hFFFF_FFEB);

    do_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2, st, ina0, dbusy, dhi, dlo);
    chk("multu_stalls", st, 3);
    chk("multu_hi", hi, 1);
    chk("multu_lo", lo, 64'hFFFF_FFFE);

    do_op(MD_OP_DIVU, 32'd100, 32'd7, st, ina0, dbusy, dhi, dlo);
    chk("divu_stalls", st, 33);
    chk("divu_ina_idle", ina0, 0);
    chk("divu_lo", lo, 14);
    chk("divu_hi", hi, 2);

    do_op(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, st, ina0, dbusy, dhi, dlo);
    chk("div_neg_lo", lo, 64'hFFFF_FFFD);
    chk("div_neg_hi", hi, 64'hFFFF_FFFF);

    do_op(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, ina0, dbusy, dhi, dlo);
    chk("div_ovf_lo", lo, 64'h8000_0000);
    chk("div_ovf_hi", hi, 0);

    do_op(MD_OP_DIVU, 32'd5, 32'd0, st, ina0, dbusy, dhi, dlo);
    chk("div0_stalls", st, 1);
    chk("div0_lo", lo, 64'hFFFF_FFFF);
    chk("div0_hi", hi, 5);

    // Flush in stall cycle 10 of a DIVU; HI/LO must keep 5 / FFFFFFFF.
    op_valid = 1'b1; op_r = MD_OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", stallreq, 0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_stall_after", stallreq, 0);
    chk("flush_hi", hi, 5);
    chk("flush_lo", lo, 64'hFFFF_FFFF);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_late_hi", hi, 5);
    chk("flush_late_lo", lo, 64'hFFFF_FFFF);

    do_op(MD_OP_MTHI, 32'h1234, 32'd0, st, ina0, dbusy, dhi, dlo);
    chk("mthi_stalls", st, 0);
    chk("mthi_hi", hi, 64'h1234);
    chk("mthi_lo_keep", lo, 64'hFFFF_FFFF);
    do_op(MD_OP_DIV, 32'd20, 32'hFFFF_FFFA, st, ina0, dbusy, dhi, dlo);
    chk("mthi_div_lo", lo, 64'hFFFF_FFFD);
    chk("mthi_div_hi", hi, 2);

    do_op(MD_OP_MTLO, 32'hABCD, 32'd0, st, ina0, dbusy, dhi, dlo);
    chk("mtlo_lo", lo, 64'hABCD);
    chk("mtlo_hi_keep", hi, 2);

    do_op(MD_OP_DIVU, 32'd1000, 32'd10, st, ina0, dbusy, dhi, dlo);
    chk("b2b1_done_lo", dlo, 100);
    chk("b2b1_done_hi", dhi, 0);
    do_op(MD_OP_DIVU, 32'd17, 32'd5, st, ina0, dbusy, dhi, dlo);
    chk("b2b2_stalls", st, 33);
    chk("b2b2_lo", lo, 3);
    chk("b2b2_hi", hi, 2);

    // Reset while in MUL count 0.
    op_valid = 1'b1; op_r = MD_OP_MULT; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    chk("rst_mid_stall", stallreq, 0);
    chk("rst_mid_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
